input_port: RTL and testbench
=============================

# input_port

Debounced, synchronized input register for the CPU: the input-side counterpart of the LED output path. It samples an asynchronous raw switch/button vector in the CLK domain, accepts a new value only after it has been stable for DEBOUNCE cycles, and latches each accepted value into a holding register. The CPU consumes that register through a VALID/READ handshake, and a sticky OVERRUN flags any accepted value that replaced unread data.

## Interface

Parameters:
- REGSIZE, 8: width of the input vector; matches the CPU register width.
- DEBOUNCE, 10_000: stability window in CLK cycles; legal range ≥ 2; small values are for simulation.

Ports:
- CLK  input  1  system clock; all state is updated on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- SWITCH  input  REGSIZE  raw asynchronous switch/button levels.
- READ  input  1  one-cycle CPU strobe that consumes IN; ignored while VALID=0.
- IN  output  REGSIZE  last accepted debounced value.
- VALID  output  1  IN holds a value not yet consumed.
- OVERRUN  output  1  sticky; an accepted value overwrote unread data.

## Operation

- Synchronizer: two flops per bit (SYNC1, then SYNC2); only SYNC2 is used downstream.
- Internal registers:
  - CAND: candidate value.
  - STABLE: last accepted value.
  - CNT: counter, width clog2(DEBOUNCE).
  - FSM state.
- FSM states:
  - IDLE: SYNC2 == CAND and CAND == STABLE; CNT held at 0.
  - SETTLING: CAND != STABLE, or a change was just observed.
- Transitions (first match wins):
  - Any state, SYNC2 != CAND: CAND <= SYNC2, CNT <= 0, go to SETTLING. A bounce restarts the window.
  - SETTLING, SYNC2 == CAND, CNT < DEBOUNCE-1: CNT <= CNT+1.
  - SETTLING, SYNC2 == CAND, CNT == DEBOUNCE-1, CAND != STABLE: commit. STABLE <= CAND, IN <= CAND, go to IDLE, CNT <= 0.
  - SETTLING, SYNC2 == CAND, CNT == DEBOUNCE-1, CAND == STABLE (input bounced back to the old value): no commit; go to IDLE.
- VALID/OVERRUN on each edge:
  - Commit and VALID=0: VALID <= 1.
  - Commit, VALID=1, READ=1: IN takes the new value, VALID stays 1, OVERRUN unchanged. The old value counts as consumed.
  - Commit, VALID=1, READ=0: IN overwritten, OVERRUN <= 1.
  - No commit, READ=1, VALID=1: VALID <= 0, OVERRUN <= 0.
  - READ while VALID=0: no effect.
- CNT never wraps. It saturates at DEBOUNCE-1 only transiently, because that state always exits on the next edge.

## Timing

- Reset values, applied asynchronously while RESET=1: SYNC1, SYNC2, CAND, STABLE, IN = 0; CNT=0; state IDLE; VALID=0; OVERRUN=0.
- Raw change to accepted value: SWITCH changes before edge k and is held.
  - SYNC2 reflects it after edge k+1.
  - CAND updates at edge k+2.
  - Commit, and VALID rising, at edge k+2+DEBOUNCE.
- Handshake: READ sampled at edge j with VALID=1 gives VALID=0 after edge j. IN stays unchanged until the next commit.
- Outputs are registered; there is no combinational path from SWITCH or READ to any output.
- Reset mid-SETTLING: the pending candidate is discarded. After RESET deasserts, a held nonzero SWITCH is re-debounced from scratch and produces a commit, because STABLE=0.
- Multiple bits changing on different cycles: each change restarts the window. One commit carries the whole final vector.

## Test plan

- DEBOUNCE=4, reset, SWITCH=8'hA5 at edge k and held -> VALID=1 and IN=8'hA5 after edge k+6; OVERRUN=0; READ pulse -> VALID=0 next edge, IN still 8'hA5.
- DEBOUNCE=4, SWITCH toggles 8'h01/8'h00 every 2 cycles for 20 cycles, then holds 8'h01 -> no VALID during toggling; single commit of 8'h01 exactly 6 cycles after the final change.
- Glitch: from accepted 8'h00, SWITCH=8'h10 for 3 cycles, then 8'h00 -> CAND returns to STABLE, no commit, VALID stays 0.
- Overrun: commit 8'h11, no READ, then commit 8'h22 -> IN=8'h22, VALID=1, OVERRUN=1; READ -> VALID=0, OVERRUN=0.
- Simultaneous: READ asserted on the same edge as commit of 8'h33 while VALID=1 -> IN=8'h33, VALID=1, OVERRUN=0.
- Async reset asserted mid-SETTLING (CNT=2) with SWITCH=8'hFF held -> all outputs 0 immediately; after release, commit of 8'hFF at DEBOUNCE+2 edges after the release edge.

Source files
------------

// File: rtl/input_port.sv
// Debounced, synchronized input register with a VALID/READ handshake and a sticky
// OVERRUN flag for accepted values that replace unread data.
module input_port #(
  parameter int REGSIZE  = 8,
  parameter int DEBOUNCE = 10_000
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [REGSIZE-1:0] SWITCH,
  input  logic               READ,
  output logic [REGSIZE-1:0] IN,
  output logic               VALID,
  output logic               OVERRUN
);

  localparam int CNT_W = $clog2(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    SETTLING = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [REGSIZE-1:0] sync1_q, sync1_d;
  logic [REGSIZE-1:0] sync2_q, sync2_d;
  logic [REGSIZE-1:0] cand_q, cand_d;
  logic [REGSIZE-1:0] stable_q, stable_d;
  logic [REGSIZE-1:0] in_q, in_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               commit;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      stable_q  <= '0;
      in_q      <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cand_q    <= cand_d;
      stable_q  <= stable_d;
      in_q      <= in_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sync1_d   = SWITCH;
    sync2_d   = sync1_q;
    cand_d    = cand_q;
    stable_d  = stable_q;
    in_d      = in_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    commit    = 1'b0;

    // Any change of the synchronized input restarts the stability window.
    if (sync2_q != cand_q) begin
      cand_d  = sync2_q;
      cnt_d   = '0;
      state_d = SETTLING;
    end else if (state_q == SETTLING) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        commit  = (cand_q != stable_q);
      end
    end

    if (commit) begin
      stable_d = cand_q;
      in_d     = cand_q;
      // A READ coinciding with the commit consumes the old value, so no overrun.
      if (!valid_q) begin
        valid_d = 1'b1;
      end else if (!READ) begin
        overrun_d = 1'b1;
      end
    end else if (READ && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  assign IN      = in_q;
  assign VALID   = valid_q;
  assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_input_port.sv
// Directed bench for input_port with DEBOUNCE=4: commit latency, bounce rejection,
// glitch filtering, overrun, read-on-commit and asynchronous reset mid-settling.
module tb_input_port;

  localparam int REGSIZE  = 8;
  localparam int DEBOUNCE = 4;
  // Edges from the first edge after a SWITCH change up to and including the commit edge.
  localparam int LAT = DEBOUNCE + 3;

  logic               CLK = 1'b0;
  logic               RESET;
  logic [REGSIZE-1:0] SWITCH;
  logic               READ;
  logic [REGSIZE-1:0] IN;
  logic               VALID;
  logic               OVERRUN;

  int n_vec  = 0;
  int n_miss = 0;

  input_port #(.REGSIZE(REGSIZE), .DEBOUNCE(DEBOUNCE)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .SWITCH  (SWITCH),
    .READ    (READ),
    .IN      (IN),
    .VALID   (VALID),
    .OVERRUN (OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Call right after SWITCH changed on a negedge; returns edges until VALID rises.
  task automatic edges_to_valid(output int n);
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge CLK); #1;
      if (VALID) begin
        n = i;
        return;
      end
    end
    n = 99;
  endtask

  task automatic read_pulse();
    @(negedge CLK); READ = 1'b1;
    @(posedge CLK); #1; READ = 1'b0;
  endtask

  int n;
  int early;

  initial begin
    RESET  = 1'b1;
    SWITCH = '0;
    READ   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in", IN, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_overrun", OVERRUN, 0);
    @(negedge CLK); RESET = 1'b0;

    // Basic commit latency and handshake.
    repeat (2) @(negedge CLK);
    SWITCH = 8'hA5;
    edges_to_valid(n);
    chk("a5_latency", n, LAT);
    chk("a5_in", IN, 8'hA5);
    chk("a5_overrun", OVERRUN, 0);
    read_pulse();
    chk("a5_read_valid", VALID, 0);
    chk("a5_read_in", IN, 8'hA5);

    // Bouncing input: no commit while toggling every 2 cycles.
    early = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); SWITCH = (i % 2 == 0) ? 8'h01 : 8'h00;
      repeat (2) begin
        @(posedge CLK); #1;
        if (VALID) early++;
      end
    end
    chk("bounce_no_valid", early, 0);
    @(negedge CLK); SWITCH = 8'h01;
    edges_to_valid(n);
    chk("bounce_latency", n, LAT);
    chk("bounce_in", IN, 8'h01);
    read_pulse();
    repeat (12) @(posedge CLK);
    #1;
    chk("bounce_single_commit", VALID, 0);

    // Glitch shorter than the window is filtered back to the stable value.
    @(negedge CLK); SWITCH = 8'h00;
    edges_to_valid(n);
    chk("zero_latency", n, LAT);
    read_pulse();
    @(negedge CLK); SWITCH = 8'h10;
    repeat (3) @(negedge CLK);
    SWITCH = 8'h00;
    early = 0;
    repeat (15) begin
      @(posedge CLK); #1;
      if (VALID) early++;
    end
    chk("glitch_no_valid", early, 0);
    chk("glitch_in", IN, 8'h00);

    // Overrun on unread data, cleared by READ.
    @(negedge CLK); SWITCH = 8'h11;
    edges_to_valid(n);
    chk("ovr_first_in", IN, 8'h11);
    @(negedge CLK); SWITCH = 8'h22;
    repeat (LAT + 2) @(posedge CLK);
    #1;
    chk("ovr_in", IN, 8'h22);
    chk("ovr_valid", VALID, 1);
    chk("ovr_flag", OVERRUN, 1);
    read_pulse();
    chk("ovr_read_valid", VALID, 0);
    chk("ovr_read_flag", OVERRUN, 0);

    // READ on the same edge as a commit while VALID=1.
    @(negedge CLK); SWITCH = 8'h44;
    edges_to_valid(n);
    chk("sim_pre_in", IN, 8'h44);
    @(negedge CLK); SWITCH = 8'h33;
    repeat (LAT - 1) @(posedge CLK);
    #1;
    chk("sim_pre_commit_in", IN, 8'h44);
    @(negedge CLK); READ = 1'b1;
    @(posedge CLK); #1; READ = 1'b0;
    chk("sim_in", IN, 8'h33);
    chk("sim_valid", VALID, 1);
    chk("sim_overrun", OVERRUN, 0);
    read_pulse();
    chk("sim_read_valid", VALID, 0);

    // Async reset while settling (CNT=2), then a full re-debounce of 8'hFF.
    @(negedge CLK); SWITCH = 8'hFF;
    repeat (5) @(posedge CLK);
    #1;
    chk("mid_valid", VALID, 0);
    RESET = 1'b1;
    #1;
    chk("arst_in", IN, 0);
    chk("arst_valid", VALID, 0);
    chk("arst_overrun", OVERRUN, 0);
    @(posedge CLK);
    @(negedge CLK); RESET = 1'b0;
    edges_to_valid(n);
    chk("arst_latency", n, LAT);
    chk("arst_commit_in", IN, 8'hFF);
    chk("arst_commit_overrun", OVERRUN, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
